lsu_ctrl: RTL

//  Load/store initiator between core datapath and byte-masked data memory (word read combinational, byte-lane write at posedge).

---
 rtl/lsu_ctrl_if.sv | 34 +++
 rtl/lsu_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus the memory-beat bus of the load/store unit.
// The slave modport is the load/store controller's view of the bus. The master modport is
// the view of the environment that holds both the core side and the data memory.
interface lsu_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        input  i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );

    modport master (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        output i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator driving a byte-masked, word-wide data memory.
// One request per handshake. Each request becomes one or two word-aligned beats.
// Build option MISALIGN_SPLIT_EN: when defined, a word-crossing access is split into
// BEAT0 and BEAT1. When it is not defined, a word-crossing access is rejected with an
// error, and no BEAT1 state or high-word capture register is built.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready; accept a request and decode its error conditions
// S_BEAT0 | first (or only) word beat; a load captures the low word
// S_BEAT1 | second beat of a word-crossing access; a load captures the high word
// S_RESP  | one-cycle response carrying the extended data or the error flag
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic       i_clk,
    input  logic       i_reset,
    lsu_ctrl_if.slave  bus
);

`ifdef MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
    localparam int   MW       = 8;
    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;
`else
    localparam logic SPLIT_EN = 1'b0;
    localparam int   MW       = 4;
    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_RESP} state_t;
`endif

    state_t      state, state_nxt;
    logic        accept;
    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic        req_cross, req_err;

    logic        r_we, r_unsigned, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_lo;
`ifdef MISALIGN_SPLIT_EN
    logic        r_cross;
    logic [31:0] r_hi;
`endif

    logic [1:0]    off;
    logic [3:0]    base;
    logic [MW-1:0] lane_mask;
    logic [31:0]   ld_word, ld_ext;

    assign accept = bus.i_req_valid && (state == S_IDLE);

    // Decode the incoming request: its width, whether it crosses a word, and whether it is an error.
    always_comb begin
        case (bus.i_req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_cross = ({1'b0, bus.i_req_addr[1:0]} + req_nbytes) > 3'd4;
        // The last-byte address uses 33 bits, so an access near 0xFFFFFFFF cannot wrap to 0.
        req_last  = {1'b0, bus.i_req_addr} + {30'd0, req_nbytes} - 33'd1;
        req_err   = (bus.i_req_size == 2'b11) || (req_last >= 33'(MEM_BYTES))
                    || (req_cross && !SPLIT_EN);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Latch the request on accept, because the request inputs may change after the handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else if (accept) begin
            r_we       <= bus.i_req_we;
            r_unsigned <= bus.i_req_unsigned;
            r_err      <= req_err;
            r_size     <= bus.i_req_size;
            r_addr     <= bus.i_req_addr;
            r_wdata    <= bus.i_req_wdata;
        end
    end

    // Capture the memory read words during load beats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lo <= 32'd0;
        end else if (state == S_BEAT0 && !r_we) begin
            r_lo <= bus.i_mem_rdata;
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Record whether the access crosses a word, and capture the high word of a crossing load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cross <= 1'b0;
            r_hi    <= 32'd0;
        end else begin
            if (accept)                       r_cross <= req_cross;
            if (state == S_BEAT1 && !r_we)    r_hi    <= bus.i_mem_rdata;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = req_err ? S_RESP : S_BEAT0;
`ifdef MISALIGN_SPLIT_EN
            S_BEAT0: state_nxt = r_cross ? S_BEAT1 : S_RESP;
            S_BEAT1: state_nxt = S_RESP;
`else
            S_BEAT0: state_nxt = S_RESP;
`endif
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane mask, and the load data aligned to bit 0 and then sign- or zero-extended.
    always_comb begin
        off = r_addr[1:0];
        case (r_size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        lane_mask = MW'(base) << off;
`ifdef MISALIGN_SPLIT_EN
        ld_word = 32'({r_hi, r_lo} >> {off, 3'b000});
`else
        ld_word = r_lo >> {off, 3'b000};
`endif
        case (r_size)
            2'b00:   ld_ext = {{24{!r_unsigned && ld_word[7]}},  ld_word[7:0]};
            2'b01:   ld_ext = {{16{!r_unsigned && ld_word[15]}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // Drive the handshake, response and memory-beat outputs from the current state.
    // The write strobe is also gated by reset, so no byte is written in any cycle that reset is high.
    always_comb begin
        bus.o_req_ready = (state == S_IDLE);
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_rdata = 32'd0;
        bus.o_rsp_err   = 1'b0;
        bus.o_mem_addr  = 32'd0;
        bus.o_mem_wdata = 32'd0;
        bus.o_mem_bmask = 4'd0;
        bus.o_mem_wren  = 1'b0;
        case (state)
            S_BEAT0: begin
                bus.o_mem_addr  = {r_addr[31:2], 2'b00};
                bus.o_mem_bmask = lane_mask[3:0];
                bus.o_mem_wdata = r_wdata << {off, 3'b000};
                bus.o_mem_wren  = r_we && !i_reset;
            end
`ifdef MISALIGN_SPLIT_EN
            S_BEAT1: begin
                bus.o_mem_addr  = {r_addr[31:2], 2'b00} + 32'd4;
                bus.o_mem_bmask = lane_mask[7:4];
                bus.o_mem_wdata = r_wdata >> {3'd4 - {1'b0, off}, 3'b000};
                bus.o_mem_wren  = r_we && !i_reset;
            end
`endif
            S_RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = r_err;
                bus.o_rsp_rdata = (r_err || r_we) ? 32'd0 : ld_ext;
            end
            default: ;
        endcase
    end

endmodule
